// File: rtl/eu_ctrl_pkg.sv
// Shared types for the execution-unit command scheduler: command opcodes and FSM states.
package eu_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_NOP        = 2'b00,
        OP_FETCH      = 2'b01,
        OP_EXEC       = 2'b10,
        OP_FETCH_EXEC = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE_F,
        ST_WAIT_F,
        ST_ISSUE_X,
        ST_WAIT_X
    } state_e;

    function automatic logic op_has_fetch(input op_e op);
        return (op == OP_FETCH) || (op == OP_FETCH_EXEC);
    endfunction

endpackage

// File: rtl/eu_cmd_fifo.sv
// Power-of-2 command FIFO with occupancy level; pushes are dropped while full.
module eu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == (PTR_W+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/eu_cmd_sched.sv
// Queued FETCH/EXEC command scheduler for execution sub-units.
// Optional wait-state watchdog enabled by defining EU_CMD_SCHED_TIMEOUT_EN.
module eu_cmd_sched
    import eu_ctrl_pkg::*;
#(
    parameter int SDRAM_ADDR_W = 32,
    parameter int SUB_NUM      = 4,
    parameter int QUEUE_DEPTH  = 4,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [$clog2(SUB_NUM)-1:0]   cmd_sub_idx,
    input  logic [SDRAM_ADDR_W-1:0]      cmd_addr,
    output logic                         fetch,
    output logic                         exec,
    output logic [$clog2(SUB_NUM)-1:0]   sub_idx,
    output logic [SDRAM_ADDR_W-1:0]      fetch_addr,
    input  logic [SUB_NUM-1:0]           sub_done,
    output logic                         busy,
    output logic [$clog2(QUEUE_DEPTH):0] q_level,
    output logic                         err_timeout
);
    localparam int SUB_W = $clog2(SUB_NUM);
    localparam int ENT_W = 2 + SUB_W + SDRAM_ADDR_W;

    if (SUB_NUM < 2 || QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0 || TIMEOUT_CYC < 2)
    begin : g_param_check
        $error("eu_cmd_sched: illegal parameter set");
    end

    logic [ENT_W-1:0]        head;
    logic                    q_full, q_empty, push, pop, done_hit;
    op_e                     head_op;
    logic [SUB_W-1:0]        head_sub;
    logic [SDRAM_ADDR_W-1:0] head_addr;

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic [SUB_W-1:0]        sub_idx_q, sub_idx_d;
    logic [SDRAM_ADDR_W-1:0] addr_q, addr_d;
    logic                    fetch_q, fetch_d, exec_q, exec_d;

    assign cmd_ready = !q_full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == ST_IDLE) && !q_empty;
    assign head_op   = op_e'(head[ENT_W-1 -: 2]);
    assign head_sub  = head[SDRAM_ADDR_W +: SUB_W];
    assign head_addr = head[SDRAM_ADDR_W-1:0];
    assign done_hit  = sub_done[sub_idx_q];

    eu_cmd_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({cmd_op, cmd_sub_idx, cmd_addr}),
        .dout  (head),
        .full  (q_full),
        .empty (q_empty),
        .level (q_level)
    );

`ifdef EU_CMD_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             wd_expired;

    // Last permitted wait cycle; a sub_done in that same cycle still wins.
    assign wd_expired  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sub_idx_d = sub_idx_q;
        addr_d    = addr_q;
        fetch_d   = 1'b0;
        exec_d    = 1'b0;
`ifdef EU_CMD_SCHED_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    op_d      = head_op;
                    sub_idx_d = head_sub;
                    addr_d    = head_addr;
                    if (op_has_fetch(head_op)) begin
                        state_d = ST_ISSUE_F;
                        fetch_d = 1'b1;
                    end else if (head_op == OP_EXEC) begin
                        state_d = ST_ISSUE_X;
                        exec_d  = 1'b1;
                    end
                end
            end
            ST_ISSUE_F: begin
                state_d = ST_WAIT_F;
`ifdef EU_CMD_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_ISSUE_X: begin
                state_d = ST_WAIT_X;
`ifdef EU_CMD_SCHED_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT_F, ST_WAIT_X: begin
                if (done_hit) begin
                    if (state_q == ST_WAIT_F && op_q == OP_FETCH_EXEC) begin
                        state_d = ST_ISSUE_X;
                        exec_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef EU_CMD_SCHED_TIMEOUT_EN
                else if (wd_expired) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NOP;
            sub_idx_q <= '0;
            addr_q    <= '0;
            fetch_q   <= 1'b0;
            exec_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            sub_idx_q <= sub_idx_d;
            addr_q    <= addr_d;
            fetch_q   <= fetch_d;
            exec_q    <= exec_d;
        end
    end

`ifdef EU_CMD_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`endif

    assign fetch      = fetch_q;
    assign exec       = exec_q;
    assign sub_idx    = sub_idx_q;
    assign fetch_addr = addr_q;
    assign busy       = (state_q != ST_IDLE) || !q_empty;

endmodule

// File: doc/eu_cmd_sched.md
EU_CMD_SCHED -- requirements
Module: eu_cmd_sched

Interface
REQ-001 SHALL have parameter SDRAM_ADDR_W, default 32, the fetch address width.
REQ-002 SHALL have parameter SUB_NUM, default 4, the number of execution sub-units; the legal range is 2 or more.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4, the number of command queue entries; it SHALL be a power of 2 and at least 2.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 1024, the wait-state watchdog limit.
REQ-005 SHALL use one clock and a synchronous, active-low reset.
REQ-006 SHALL have the following ports:
- clk, in, 1: the single clock.
- rst_n, in, 1: synchronous, active-low reset.
- cmd_valid, in, 1: the command offer.
- cmd_ready, out, 1: the queue has space.
- cmd_op, in, 2: 00 NOP, 01 FETCH, 10 EXEC, 11 FETCH_EXEC.
- cmd_sub_idx, in, clog2(SUB_NUM): the target sub-unit.
- cmd_addr, in, SDRAM_ADDR_W: the fetch address.
- fetch, out, 1: one-cycle fetch strobe.
- exec, out, 1: one-cycle exec strobe.
- sub_idx, out, clog2(SUB_NUM): the active sub-unit, held for the whole command.
- fetch_addr, out, SDRAM_ADDR_W: the active address, held for the whole command.
- sub_done, in, SUB_NUM: per-sub-unit completion pulse.
- busy, out, 1: the FSM is not in IDLE, or the queue is not empty.
- q_level, out, clog2(QUEUE_DEPTH)+1: the queue occupancy.
- err_timeout, out, 1: sticky watchdog error.

Function
REQ-007 A push SHALL occur when cmd_valid and cmd_ready are both high.
REQ-008 cmd_ready SHALL equal (q_level != QUEUE_DEPTH).
REQ-009 When the queue is full, a push SHALL NOT occur, even if a pop happens in the same cycle.
REQ-010 When a push and a pop occur in the same cycle on a non-full queue, q_level SHALL be unchanged.
REQ-011 The FSM SHALL have the states IDLE, ISSUE_F, WAIT_F, ISSUE_X and WAIT_X.
REQ-012 In IDLE with the queue non-empty, the FSM SHALL pop the head entry and latch sub_idx and fetch_addr.
REQ-013 After the pop, the FSM SHALL go to:
- ISSUE_F for FETCH or FETCH_EXEC;
- ISSUE_X for EXEC;
- IDLE for NOP, with no strobes.
REQ-014 ISSUE_F SHALL drive fetch high for exactly one cycle, then go to WAIT_F.
REQ-015 ISSUE_X SHALL drive exec high for exactly one cycle, then go to WAIT_X.
REQ-016 WAIT_F SHALL exit on sub_done[sub_idx]: to ISSUE_X if the op is FETCH_EXEC, otherwise to IDLE.
REQ-017 WAIT_X SHALL exit to IDLE on sub_done[sub_idx].
REQ-018 sub_done bits for other sub-units SHALL be ignored.
REQ-019 sub_done SHALL be sampled only in the WAIT states; a pulse in an ISSUE cycle SHALL be lost.
REQ-020 Latency: for a command accepted in cycle N into an empty queue with the FSM in IDLE:
- the pop SHALL occur in cycle N+1;
- the first strobe SHALL occur in cycle N+2.
REQ-021 The FSM SHALL return to IDLE the cycle after the completing sub_done.
REQ-022 The next pop SHALL occur in the cycle the FSM is in IDLE, so there is exactly one idle cycle between commands.
REQ-023 fetch and exec SHALL never be high together, and SHALL be registered outputs.
REQ-024 The queue SHALL be first-in first-out, with power-of-2 pointer wrap-around.

Reset
REQ-025 When rst_n is low at a clock edge, the following SHALL be set to these values:
- FSM: IDLE;
- queue: empty;
- q_level: 0;
- fetch, exec: 0;
- sub_idx, fetch_addr: 0;
- busy: 0;
- err_timeout: 0;
- watchdog count: 0.
REQ-026 A reset mid-command SHALL discard the active command and all queued commands, with no strobe in the next cycle.
REQ-027 cmd_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-028 With macro EU_CMD_SCHED_TIMEOUT_EN defined, a counter SHALL:
- clear on entry to any WAIT state;
- increment each cycle while the FSM is in that WAIT state.
REQ-029 With EU_CMD_SCHED_TIMEOUT_EN defined, on the count reaching TIMEOUT_CYC without sub_done, the block SHALL:
- set err_timeout, which stays set until reset;
- abort the command;
- return to IDLE, with no further strobe for that command.
REQ-030 Without EU_CMD_SCHED_TIMEOUT_EN, the port err_timeout SHALL exist and be tied to 0, the WAIT states SHALL wait indefinitely, and no counter logic SHALL be present.

Structure
REQ-031 Package eu_ctrl_pkg SHALL hold the op enum (NOP, FETCH, EXEC, FETCH_EXEC) and the state enum.
REQ-032 The queue SHALL be the sub-module eu_cmd_fifo, parameterised by width and depth, with push, pop, full, empty and level ports.
REQ-033 The FSM and the output registers SHALL be in eu_cmd_sched.

Verification
REQ-034 FETCH_EXEC test:
- Stimulus: push FETCH_EXEC with sub 2 and addr 0x1000 at cycle 10; pulse sub_done=0100 at cycles 15 and 20.
- Required: fetch=1 at cycle 12, exec=1 at cycle 16, IDLE at cycle 21, sub_idx=2 and fetch_addr=0x1000 held throughout.
REQ-035 Full-queue test:
- Stimulus: with QUEUE_DEPTH=4 and sub_done held at 0, offer 6 back-to-back commands.
- Required: 5 accepted (the queue fills after the first pop), cmd_ready=0 and q_level=4.
REQ-036 Wrong-sub test:
- Stimulus: FETCH to sub 1, with sub_done=0001 then 0010.
- Required: the FSM stays in WAIT_F on 0001 and exits on 0010.
REQ-037 NOP test:
- Stimulus: push NOP then EXEC to sub 3.
- Required: no strobe for the NOP, and exec pulses 2 cycles after the NOP pop.
REQ-038 Reset test:
- Stimulus: assert rst_n=0 while in WAIT_X with 3 commands queued.
- Required: the next cycle shows q_level=0, IDLE, busy=0, and no strobes afterwards.
REQ-039 Timeout test:
- Stimulus: with EU_CMD_SCHED_TIMEOUT_EN and TIMEOUT_CYC=8, send FETCH with no sub_done.
- Required: err_timeout rises after 8 wait cycles, the FSM goes to IDLE, and the next queued command proceeds.
